// File: rtl/dot_product_pkg.sv
// Shared types and defaults for the dot-product sequencer.
package dot_product_pkg;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_LEN_W = 8;
  localparam int unsigned DEF_ACC_W = 32;
  localparam int unsigned PROD_W    = 17;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // A sum of DEPTH byte products needs 16 + clog2(DEPTH) bits; never go below PROD_W.
  function automatic int unsigned sum_w(input int unsigned depth);
    int unsigned w;
    w = 16 + $clog2(depth);
    return (w > PROD_W) ? w : PROD_W;
  endfunction

endpackage

// File: rtl/dot_product_parallel.sv
// Combinational sum of DEPTH unsigned byte-by-byte products.
module dot_product_parallel #(
  parameter int unsigned DEPTH = dot_product_pkg::DEF_DEPTH,
  parameter int unsigned SUM_W = dot_product_pkg::sum_w(DEPTH)
) (
  input  logic [8*DEPTH-1:0] i_a_vec,
  input  logic [8*DEPTH-1:0] i_b_vec,
  output logic [SUM_W-1:0]   o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_sum = o_sum + SUM_W'(i_a_vec[8*i +: 8]) * SUM_W'(i_b_vec[8*i +: 8]);
    end
  end

endmodule

// File: rtl/dot_product_sequencer.sv
// Two-stage chunked dot-product sequencer (product-sum register, then accumulator).
// Define DOT_PRODUCT_SEQ_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module dot_product_sequencer
  import dot_product_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*DEPTH-1:0] a_vec,
  input  logic [8*DEPTH-1:0] b_vec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res,
  output logic               ovf,
  output logic               busy
);

  localparam int unsigned SUM_W = sum_w(DEPTH);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [LEN_W-1:0]   r_rem;
  logic [SUM_W-1:0]   r_p;
  logic               r_p_vld;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic [SUM_W-1:0]   w_sum;
  logic               w_start;
  logic               w_xfer;
  logic [ACC_W:0]     w_acc_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_nxt;

  dot_product_parallel #(
    .DEPTH (DEPTH),
    .SUM_W (SUM_W)
  ) u_parallel (
    .i_a_vec (a_vec),
    .i_b_vec (b_vec),
    .o_sum   (w_sum)
  );

  always_comb begin
    w_start   = (r_state == StIdle) && start;
    in_ready  = (r_state == StRun) && (r_rem != '0);
    w_xfer    = in_valid && in_ready;
    w_acc_sum = {1'b0, r_acc} + (ACC_W + 1)'(r_p);
    w_carry   = w_acc_sum[ACC_W];
`ifdef DOT_PRODUCT_SEQ_SAT_EN
    w_acc_nxt = w_carry ? '1 : w_acc_sum[ACC_W-1:0];
`else
    w_acc_nxt = w_acc_sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_nxt = (len == '0) ? StDone : StRun;
      StRun:   if (w_xfer && (r_rem == LEN_W'(1))) w_state_nxt = StDrain;
      // Leave only after the final product has been folded into acc.
      StDrain: if (!r_p_vld) w_state_nxt = StDone;
      StDone:  if (res_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_p     <= '0;
      r_p_vld <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_start) begin
        r_rem <= len;
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_xfer) r_rem <= r_rem - LEN_W'(1);
        if (r_p_vld) begin
          r_acc <= w_acc_nxt;
          if (w_carry) r_ovf <= 1'b1;
        end
      end
      r_p_vld <= w_xfer;
      if (w_xfer) r_p <= w_sum;
    end
  end

  assign res       = r_acc;
  assign ovf       = r_ovf;
  assign res_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Randomized self-checking bench: a 32-bit and an 18-bit accumulator instance share stimulus.
module tb_dot_product_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned ACC_W2 = 18;
`ifdef DOT_PRODUCT_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   len = '0;
  logic               in_valid = 1'b0;
  logic               res_ready = 1'b0;
  logic [8*DEPTH-1:0] a_vec = '0;
  logic [8*DEPTH-1:0] b_vec = '0;

  logic              in_ready, res_valid, ovf, busy;
  logic [ACC_W-1:0]  res;
  logic              in_ready2, res_valid2, ovf2, busy2;
  logic [ACC_W2-1:0] res2;

  dot_product_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec), .res_valid(res_valid),
    .res_ready(res_ready), .res(res), .ovf(ovf), .busy(busy)
  );

  dot_product_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ACC_W(ACC_W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready2), .a_vec(a_vec), .b_vec(b_vec), .res_valid(res_valid2),
    .res_ready(res_ready), .res(res2), .ovf(ovf2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic over the whole job.
  longint unsigned m_total;

  function automatic longint unsigned dot(input logic [8*DEPTH-1:0] a, input logic [8*DEPTH-1:0] b);
    longint unsigned s = 0;
    for (int i = 0; i < DEPTH; i++) s += 64'(a[8*i +: 8]) * 64'(b[8*i +: 8]);
    return s;
  endfunction

  function automatic longint unsigned exp_res(input longint unsigned total, input int w);
    longint unsigned lim = 64'd1 << w;
    if (total < lim) return total;
    return SAT ? (lim - 1) : (total % lim);
  endfunction

  function automatic bit exp_ovf(input longint unsigned total, input int w);
    return total >= (64'd1 << w);
  endfunction

  task automatic check_result(input string tag);
    check_eq({tag, "_valid"}, res_valid, 1);
    check_eq({tag, "_res"}, res, exp_res(m_total, ACC_W));
    check_eq({tag, "_ovf"}, ovf, exp_ovf(m_total, ACC_W));
    check_eq({tag, "_valid18"}, res_valid2, 1);
    check_eq({tag, "_res18"}, res2, exp_res(m_total, ACC_W2));
    check_eq({tag, "_ovf18"}, ovf2, exp_ovf(m_total, ACC_W2));
  endtask

  // data_mode: 0 random, 1 fixed {1,2,3,4}x{5,6,7,8}, 2 all 255.
  // vld_mode:  0 always valid, 1 random, 2 pattern 1,0,0,1 with a start pulse mid-run.
  task automatic run_job(input string tag, input int n, input int data_mode, input int vld_mode,
                         input int hold);
    int k = 0;
    int cyc = 0;
    logic [8*DEPTH-1:0] a, b;
    bit v;
    m_total = 0;
    start = 1'b1;
    len   = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    if (n > 0) begin
      check_eq({tag, "_busy"}, busy, 1);
      while (k < n && cyc < 200) begin
        case (vld_mode)
          0:       v = 1'b1;
          1:       v = 1'($urandom_range(0, 1));
          default: v = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
        case (data_mode)
          1: begin a = {8'd4, 8'd3, 8'd2, 8'd1}; b = {8'd8, 8'd7, 8'd6, 8'd5}; end
          2: begin a = '1; b = '1; end
          default: begin a = (8*DEPTH)'($urandom()); b = (8*DEPTH)'($urandom()); end
        endcase
        in_valid = v;
        a_vec    = a;
        b_vec    = b;
        start    = (vld_mode == 2) && (cyc == 1);
        if (start) len = LEN_W'(7);
        if (v && in_ready) begin
          m_total += dot(a, b);
          k++;
        end
        cyc++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      a_vec    = (8*DEPTH)'($urandom());
      if (k < n) check_eq({tag, "_xfer_timeout"}, k, n);
      check_eq({tag, "_ready_after_last"}, in_ready, 0);
      check_eq({tag, "_valid_T0"}, res_valid, 0);
      @(negedge clk);
      check_eq({tag, "_valid_T1"}, res_valid, 0);
      @(negedge clk);
    end
    check_result(tag);
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, res_valid, 1);
      check_eq({tag, "_hold_res"}, res, exp_res(m_total, ACC_W));
      check_eq({tag, "_hold_res18"}, res2, exp_res(m_total, ACC_W2));
    end
    // Handshake and a simultaneous start: the start must not launch a job.
    res_ready = 1'b1;
    start     = 1'b1;
    len       = LEN_W'(5);
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    check_eq({tag, "_idle_busy"}, busy, 0);
    check_eq({tag, "_idle_valid"}, res_valid, 0);
    check_eq({tag, "_idle_busy18"}, busy2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_res", res, 0);
    check_eq("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job("basic70", 1, 1, 0, 0);
    run_job("all255x3", 3, 2, 0, 1);
    run_job("len0", 0, 0, 0, 5);
    run_job("ovf18", 2, 2, 0, 0);

    // Abort after one of three chunks, then restart right after release.
    start    = 1'b1;
    len      = LEN_W'(3);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    a_vec    = '1;
    b_vec    = '1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", in_ready, 0);
    check_eq("abort_valid", res_valid, 0);
    check_eq("abort_res", res, 0);
    check_eq("abort_busy18", busy2, 0);
    #1 rst_n = 1'b1;
    run_job("after_abort", 1, 0, 0, 1);

    run_job("gaps", 2, 0, 2, 0);
    for (int j = 0; j < 6; j++) begin
      run_job("rand", int'($urandom_range(1, 6)), 0, 1, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
